fetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the combinational ROM port (address out; data and accessible flag back in the same cycle).
- Holds the fetch PC and buffers fetched words in a small FIFO.
- Presents them to the decode stage with a valid/ready handshake.
- Accepts PC redirects (jump, branch, exception) from the core.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a combinational ROM port from the fetch
// PC, buffers fetched words (or fetch faults) in a small FIFO and hands them
// to decode through a valid/ready handshake. Redirects flush the queue and
// reload the fetch PC; a fetch fault halts fetching until the next redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault,
  output logic        fetch_stopped
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [31:0]   fetch_pc;
  logic          stopped;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic        fault_q [DEPTH];

  logic push;
  logic pop;

  assign rom_addr      = fetch_pc;
  assign fetch_stopped = stopped;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : 32'h0;
  assign out_fault = out_valid ? fault_q[rd_ptr] : 1'b0;

  assign pop  = out_valid & out_ready;
  assign push = ~redirect_valid & ~stopped & ((count < FULL_COUNT) | pop);

  // Queue storage: an inaccessible address is recorded as a fault entry with a zero word.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= rom_accessable ? rom_data : 32'h0;
      pc_q[wr_ptr]    <= fetch_pc;
      fault_q[wr_ptr] <= ~rom_accessable;
    end
  end

  // Fetch PC, stop flag and queue bookkeeping; a redirect overrides everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      stopped  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      stopped  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (rom_accessable) begin
          fetch_pc <= fetch_pc + 32'd4;
        end else begin
          stopped <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a small ROM model feeds the fetch port and
// each scenario task checks the decode-side outputs against hand-computed values.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_accessable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        fetch_stopped;
  logic        force_acc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_accessable (rom_accessable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .fetch_stopped  (fetch_stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: three boot words, a readable window at 0x004xxxxx, and an override that makes every address readable.
  always_comb begin
    rom_accessable = 1'b0;
    rom_data       = 32'h0;
    case (rom_addr)
      32'h0000_0000: begin rom_accessable = 1'b1; rom_data = 32'h3c11_0040; end
      32'h0000_0004: begin rom_accessable = 1'b1; rom_data = 32'h2631_0000; end
      32'h0000_0008: begin rom_accessable = 1'b1; rom_data = 32'h0220_0008; end
      default: begin
        if (force_acc) begin
          rom_accessable = 1'b1;
          rom_data       = ~rom_addr;
        end else if (rom_addr[31:20] == 12'h004 && rom_addr[1:0] == 2'b00) begin
          rom_accessable = 1'b1;
          rom_data       = rom_addr ^ 32'h1234_0000;
        end
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr got=%h exp=00000000", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc got=%h exp=00000000", out_pc); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_fault got=%b exp=0", out_fault); end
    checks++; if (fetch_stopped !== 1'b0) begin errors++; $display("[TB] FAIL reset_stopped got=%b exp=0", fetch_stopped); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_rom_addr got=%h exp=00000000", rom_addr); end
  endtask

  task automatic test_boot_stream();
    logic [31:0] exp_instr [3];
    logic [31:0] exp_pc [3];
    exp_instr[0] = 32'h3c11_0040; exp_pc[0] = 32'h0;
    exp_instr[1] = 32'h2631_0000; exp_pc[1] = 32'h4;
    exp_instr[2] = 32'h0220_0008; exp_pc[2] = 32'h8;
    out_ready = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== exp_instr[i] || out_pc !== exp_pc[i] || out_fault !== 1'b0)
        begin errors++; $display("[TB] FAIL boot_word%0d got v=%b instr=%h pc=%h f=%b exp v=1 instr=%h pc=%h f=0", i, out_valid, out_instr, out_pc, out_fault, exp_instr[i], exp_pc[i]); end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'hC || out_fault !== 1'b1)
      begin errors++; $display("[TB] FAIL boot_fault_entry got v=%b instr=%h pc=%h f=%b exp v=1 instr=0 pc=c f=1", out_valid, out_instr, out_pc, out_fault); end
    checks++; if (fetch_stopped !== 1'b1) begin errors++; $display("[TB] FAIL boot_stopped got=%b exp=1", fetch_stopped); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'hC || fetch_stopped !== 1'b1)
        begin errors++; $display("[TB] FAIL stopped_idle%0d got v=%b addr=%h stop=%b exp v=0 addr=c stop=1", i, out_valid, rom_addr, fetch_stopped); end
    end
  endtask

  task automatic test_backpressure_fault_redirect();
    out_ready = 1'b0;
    reset     = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3c11_0040 || rom_addr !== 32'h8)
      begin errors++; $display("[TB] FAIL bp_full got v=%b instr=%h addr=%h exp v=1 instr=3c110040 addr=8", out_valid, out_instr, rom_addr); end
    step();
    checks++;
    if (out_instr !== 32'h3c11_0040 || rom_addr !== 32'h8)
      begin errors++; $display("[TB] FAIL bp_hold got instr=%h addr=%h exp instr=3c110040 addr=8", out_instr, rom_addr); end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h2631_0000 || out_pc !== 32'h4)
      begin errors++; $display("[TB] FAIL bp_release got v=%b instr=%h pc=%h exp v=1 instr=26310000 pc=4", out_valid, out_instr, out_pc); end
    step();
    checks++;
    if (out_instr !== 32'h0220_0008 || out_pc !== 32'h8 || fetch_stopped !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_fault_queued got instr=%h pc=%h stop=%b exp instr=02200008 pc=8 stop=1", out_instr, out_pc, fetch_stopped); end
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || rom_addr !== 32'hC)
      begin errors++; $display("[TB] FAIL stopped_full got v=%b pc=%h addr=%h exp v=1 pc=8 addr=c", out_valid, out_pc, rom_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fetch_stopped !== 1'b0 || rom_addr !== 32'h0040_0000)
      begin errors++; $display("[TB] FAIL redirect_flush got v=%b stop=%b addr=%h exp v=0 stop=0 addr=00400000", out_valid, fetch_stopped, rom_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 || out_instr !== 32'h1274_0000 || out_fault !== 1'b0)
      begin errors++; $display("[TB] FAIL redirect_first got v=%b pc=%h instr=%h f=%b exp v=1 pc=00400000 instr=12740000 f=0", out_valid, out_pc, out_instr, out_fault); end
    step();
    checks++;
    if (out_pc !== 32'h0040_0004 || out_instr !== 32'h1274_0004)
      begin errors++; $display("[TB] FAIL redirect_second got pc=%h instr=%h exp pc=00400004 instr=12740004", out_pc, out_instr); end
  endtask

  task automatic test_wrap();
    force_acc      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 32'hFFFF_FFFC)
      begin errors++; $display("[TB] FAIL wrap_flush got v=%b addr=%h exp v=0 addr=fffffffc", out_valid, rom_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h0000_0003 || rom_addr !== 32'h0)
      begin errors++; $display("[TB] FAIL wrap_last got v=%b pc=%h instr=%h addr=%h exp v=1 pc=fffffffc instr=00000003 addr=0", out_valid, out_pc, out_instr, rom_addr); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h3c11_0040)
      begin errors++; $display("[TB] FAIL wrap_zero got v=%b pc=%h instr=%h exp v=1 pc=0 instr=3c110040", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    force_acc = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== 32'h8)
      begin errors++; $display("[TB] FAIL mid_two_queued got v=%b pc=%h addr=%h exp v=1 pc=0 addr=8", out_valid, out_pc, rom_addr); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 32'h0 || out_pc !== 32'h0 || fetch_stopped !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_async_reset got v=%b addr=%h pc=%h stop=%b exp v=0 addr=0 pc=0 stop=0", out_valid, rom_addr, out_pc, fetch_stopped); end
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3c11_0040 || out_pc !== 32'h0)
      begin errors++; $display("[TB] FAIL restart_first got v=%b instr=%h pc=%h exp v=1 instr=3c110040 pc=0", out_valid, out_instr, out_pc); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h2631_0000 || out_pc !== 32'h4)
      begin errors++; $display("[TB] FAIL restart_second got v=%b instr=%h pc=%h exp v=1 instr=26310000 pc=4", out_valid, out_instr, out_pc); end
  endtask

  // Scenario sequence: reset, boot stream into a fault, backpressure plus redirect, PC wrap, mid-stream reset.
  initial begin
    reset          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    force_acc      = 1'b0;
    test_reset();
    test_boot_stream();
    test_backpressure_fault_redirect();
    test_wrap();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
